// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types for the fetch/branch controller: FSM state encoding,
//   next-PC mux select encodings and execute-stage branch-select encodings.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    HOLD     = 3'd2,
    REDIRECT = 3'd3,
    HALT     = 3'd4
  } state_e;

  // next-PC mux select
  localparam logic [1:0] SEL_PC1 = 2'b00;
  localparam logic [1:0] SEL_BRA = 2'b01;
  localparam logic [1:0] SEL_RAA = 2'b10;
  localparam logic [1:0] SEL_JMP = 2'b11;

  // branch select from execute
  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JR   = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

endpackage

// File: rtl/fetch_branch_ctrl_resolve.sv
// branch_resolve
//   Combinational branch resolution for the execute-stage branch.
//   Ports:
//     ex_br_valid  in   execute holds a branch/jump
//     ex_bs[1:0]   in   branch select (none / cond / jr / jump)
//     ex_ps        in   branch polarity
//     ex_zero      in   ALU zero flag
//     taken        out  branch redirects the PC
//     sel[1:0]     out  next-PC mux select for the redirect
module branch_resolve
  import fetch_pkg::*;
(
  input  logic       ex_br_valid,
  input  logic [1:0] ex_bs,
  input  logic       ex_ps,
  input  logic       ex_zero,
  output logic       taken,
  output logic [1:0] sel
);

  // Conditional branches take when polarity and zero disagree; jumps always
  // take. A non-taken conditional collapses to SEL_PC1.
  assign sel   = {ex_bs[1], ((ex_ps ^ ex_zero) | ex_bs[1]) & ex_bs[0]};
  assign taken = ex_br_valid & (sel != SEL_PC1);

endmodule

// File: rtl/fetch_branch_ctrl.sv
// fetch_branch_ctrl
//   Sequences the PC register and its next-PC mux: fetch handshake with
//   instruction memory, load-use stalls, taken-branch redirect with wrong-path
//   squash, sticky halt, and saturating branch statistics.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     imem_req/imem_ack   fetch request / word returned for current PC
//     id_stall            load-use hold from decode
//     ex_br_valid, ex_bs, ex_ps, ex_zero   execute-stage branch info
//     halt                stop fetching (sticky until reset)
//     pc_we, pc_sel       PC load enable and next-PC mux select
//     flush_if_id/id_ex   squash pipeline registers
//     if_id_valid         IF/ID captures a valid instruction
//     halted              FSM in HALT
//     branch_cnt/taken_cnt  saturating statistics
//
//   state    | meaning
//   IDLE     | first cycle after reset, nothing issued
//   FETCH    | requesting instructions, PC+1 on each ack
//   HOLD     | load-use stall, PC and IF/ID held
//   REDIRECT | bubble cycles after a taken branch, wrong-path ignored
//   HALT     | stopped until reset
module fetch_branch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic              id_stall,
  input  logic              ex_br_valid,
  input  logic [1:0]        ex_bs,
  input  logic              ex_ps,
  input  logic              ex_zero,
  input  logic              halt,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              if_id_valid,
  output logic              halted,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] taken_cnt
);

  localparam logic [2:0]        BUBBLE_INIT = 3'(FLUSH_DEPTH - 1);
  localparam logic [STAT_W-1:0] CNT_ONE     = STAT_W'(1);
  localparam logic [STAT_W-1:0] CNT_MAX     = '1;

  state_e            state_q, state_d;
  logic [2:0]        bubble_q, bubble_d;
  logic [STAT_W-1:0] branch_cnt_q, taken_cnt_q;
  logic              taken;
  logic [1:0]        sel;
  logic              honour;

  branch_resolve u_resolve (
    .ex_br_valid (ex_br_valid),
    .ex_bs       (ex_bs),
    .ex_ps       (ex_ps),
    .ex_zero     (ex_zero),
    .taken       (taken),
    .sel         (sel)
  );

  always_comb begin
    state_d     = state_q;
    bubble_d    = bubble_q;
    imem_req    = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = SEL_PC1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if_id_valid = 1'b0;
    halted      = 1'b0;
    honour      = 1'b0;

    case (state_q)
      IDLE: state_d = halt ? HALT : FETCH;

      FETCH, HOLD: begin
        imem_req = (state_q == FETCH);
        // a branch seen alongside halt is counted but not applied
        honour   = ex_br_valid;
        if (halt) begin
          state_d = HALT;
        end else if (taken) begin
          pc_we       = 1'b1;
          pc_sel      = sel;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          bubble_d    = BUBBLE_INIT;
          state_d     = (FLUSH_DEPTH == 1) ? FETCH : REDIRECT;
        end else if (id_stall) begin
          state_d = HOLD;
        end else if (state_q == HOLD) begin
          state_d = FETCH;
        end else if (imem_ack) begin
          pc_we       = 1'b1;
          if_id_valid = 1'b1;
        end
      end

      REDIRECT: begin
        imem_req = 1'b1;
        if (halt) begin
          state_d = HALT;
        end else begin
          flush_if_id = 1'b1;
          bubble_d    = (bubble_q != 3'd0) ? bubble_q - 3'd1 : 3'd0;
          if (bubble_q <= 3'd1) state_d = FETCH;
        end
      end

      HALT: halted = 1'b1;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bubble_q     <= 3'd0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
      if (honour) begin
        if (branch_cnt_q != CNT_MAX) branch_cnt_q <= branch_cnt_q + CNT_ONE;
        if (taken && taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + CNT_ONE;
      end
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
module tb_fetch_branch_ctrl;
  localparam int FD = 2;
  localparam int SW = 2;
  localparam int CMAX = (1 << SW) - 1;

  localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_REDIR = 3, M_HALT = 4;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [1:0]    sel;
    logic          fi;
    logic          fe;
    logic          v;
    logic          h;
    logic [SW-1:0] bc;
    logic [SW-1:0] tc;
  } obs_t;

  logic clk, rst_n;
  logic imem_req, imem_ack, id_stall, ex_br_valid, ex_ps, ex_zero, halt;
  logic [1:0] ex_bs, pc_sel;
  logic pc_we, flush_if_id, flush_id_ex, if_id_valid, halted;
  logic [SW-1:0] branch_cnt, taken_cnt;

  fetch_branch_ctrl #(.FLUSH_DEPTH(FD), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .id_stall(id_stall), .ex_br_valid(ex_br_valid), .ex_bs(ex_bs),
    .ex_ps(ex_ps), .ex_zero(ex_zero), .halt(halt), .pc_we(pc_we),
    .pc_sel(pc_sel), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .if_id_valid(if_id_valid), .halted(halted), .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  obs_t exp_q[$];

  // reference model state
  int m_mode, m_left, m_br, m_tk;

  function automatic obs_t actual();
    return {imem_req, pc_we, pc_sel, flush_if_id, flush_id_ex, if_id_valid,
            halted, branch_cnt, taken_cnt};
  endfunction

  // scoreboard monitor: compares every cycle that has a pending expectation
  int mon_cyc = 0;
  obs_t mon_e, mon_a;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = actual();
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL outputs cyc=%0d actual(req,we,sel,fi,fe,v,h,bc,tc)=%b required=%b",
                 mon_cyc, mon_a, mon_e);
      end
      mon_cyc++;
    end
  end

  function automatic void model_reset();
    m_mode = M_IDLE; m_left = 0; m_br = 0; m_tk = 0;
  endfunction

  // Expected outputs for the current cycle, then advance the model.
  function automatic obs_t model_step(input logic ack, stall, brv,
                                      input logic [1:0] bs,
                                      input logic ps, zero, hlt);
    obs_t e;
    logic tk;
    logic [1:0] s;
    int nxt;
    e = '0;
    e.bc = SW'(m_br);
    e.tc = SW'(m_tk);
    tk = 1'b0;
    s = 2'b00;
    if (brv) begin
      case (bs)
        2'b01: if (ps != zero) begin tk = 1'b1; s = 2'b01; end
        2'b10: begin tk = 1'b1; s = 2'b10; end
        2'b11: begin tk = 1'b1; s = 2'b11; end
        default: ;
      endcase
    end
    nxt = m_mode;
    case (m_mode)
      M_IDLE: nxt = hlt ? M_HALT : M_FETCH;
      M_FETCH, M_HOLD: begin
        e.req = (m_mode == M_FETCH);
        if (hlt) nxt = M_HALT;
        else if (tk) begin
          e.we = 1'b1; e.sel = s; e.fi = 1'b1; e.fe = 1'b1;
          m_left = FD - 1;
          nxt = (FD == 1) ? M_FETCH : M_REDIR;
        end else if (stall) nxt = M_HOLD;
        else if (m_mode == M_HOLD) nxt = M_FETCH;
        else if (ack) begin e.we = 1'b1; e.v = 1'b1; end
        if (brv) begin
          if (m_br < CMAX) m_br++;
          if (tk && m_tk < CMAX) m_tk++;
        end
      end
      M_REDIR: begin
        e.req = 1'b1;
        if (hlt) nxt = M_HALT;
        else begin
          e.fi = 1'b1;
          m_left--;
          if (m_left == 0) nxt = M_FETCH;
        end
      end
      default: e.h = 1'b1;
    endcase
    m_mode = nxt;
    return e;
  endfunction

  task automatic drive(input logic ack, stall, brv, input logic [1:0] bs,
                       input logic ps, zero, hlt);
    imem_ack = ack; id_stall = stall; ex_br_valid = brv; ex_bs = bs;
    ex_ps = ps; ex_zero = zero; halt = hlt;
    exp_q.push_back(model_step(ack, stall, brv, bs, ps, zero, hlt));
    @(posedge clk);
    #1;
  endtask

  // async reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    obs_t a;
    rst_n = 1'b0;
    #1;
    a = actual();
    checks++;
    if (a !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b required=%b", a, obs_t'('0));
    end
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    imem_ack = 0; id_stall = 0; ex_br_valid = 0; ex_bs = 0;
    ex_ps = 0; ex_zero = 0; halt = 0; rst_n = 0;
    model_reset();
    #2;
    do_reset();

    // idle then straight-line fetch
    repeat (5) drive(1, 0, 0, 2'b00, 0, 0, 0);
    // taken conditional, wrong-path branch during redirect, then resume
    drive(1, 0, 1, 2'b01, 0, 1, 0);
    drive(1, 0, 1, 2'b11, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    // not-taken conditional follows ack path
    drive(1, 0, 1, 2'b01, 1, 1, 0);
    // jump-register and jump
    drive(0, 0, 1, 2'b10, 0, 0, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    drive(1, 0, 1, 2'b11, 1, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    // waiting on memory
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    // load-use stall for 3 cycles, then resume
    repeat (3) drive(1, 1, 0, 2'b00, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    // taken jump while held overrides the stall
    drive(1, 1, 0, 2'b00, 0, 0, 0);
    drive(1, 1, 1, 2'b11, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    // more taken branches to drive counters into saturation
    repeat (3) begin
      drive(1, 0, 1, 2'b01, 1, 0, 0);
      drive(1, 0, 0, 2'b00, 0, 0, 0);
    end
    drive(1, 0, 0, 2'b00, 0, 0, 0);
    // reset in the middle of a redirect
    drive(1, 0, 1, 2'b10, 0, 0, 0);
    do_reset();
    repeat (3) drive(1, 0, 0, 2'b00, 0, 0, 0);
    // halt together with a taken branch: counted, not applied
    drive(1, 0, 1, 2'b11, 0, 0, 1);
    repeat (4) drive(1, 0, 1, 2'b11, 0, 0, 0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (m_mode == M_HALT && ($urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 149) == 0));
      end
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
